// File: rtl/cla4_registered_if.sv
// Bit-level operand/result bundle for the 4-bit registered lookahead adder.
// The master drives the operands and the slave returns the registered sum.
interface cla4_registered_if;
  logic a1, a2, a3, a4;
  logic b1, b2, b3, b4;
  logic c0;
  logic s1, s2, s3, s4;
  logic c4;

  modport master (
    output a1, a2, a3, a4, b1, b2, b3, b4, c0,
    input  s1, s2, s3, s4, c4
  );

  modport slave (
    input  a1, a2, a3, a4, b1, b2, b3, b4, c0,
    output s1, s2, s3, s4, c4
  );
endinterface

// File: rtl/cla4_registered.sv
// 4-bit carry-lookahead adder with flat carry equations and registered outputs.
// One edge of latency, no input registers; async active-low reset clears outputs.
module cla4_registered (
  input  logic               clk,
  input  logic               rst_n,
  cla4_registered_if.slave   bus
);

  logic [4:1] g, p;
  logic [4:0] c;
  logic [3:0] sum_d, sum_q;
  logic       c4_d, c4_q;

  always_comb begin
    g    = '0;
    p    = '0;
    c    = '0;
    g[1] = bus.a1 & bus.b1;
    g[2] = bus.a2 & bus.b2;
    g[3] = bus.a3 & bus.b3;
    g[4] = bus.a4 & bus.b4;
    p[1] = bus.a1 ^ bus.b1;
    p[2] = bus.a2 ^ bus.b2;
    p[3] = bus.a3 ^ bus.b3;
    p[4] = bus.a4 ^ bus.b4;

    // Each carry is a flat sum of products so no carry waits on another.
    c[0] = bus.c0;
    c[1] = g[1] | (p[1] & bus.c0);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & bus.c0);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & bus.c0);
    c[4] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
         | (p[4] & p[3] & p[2] & g[1])
         | (p[4] & p[3] & p[2] & p[1] & bus.c0);
  end

  always_comb begin
    sum_d    = '0;
    sum_d[0] = p[1] ^ c[0];
    sum_d[1] = p[2] ^ c[1];
    sum_d[2] = p[3] ^ c[2];
    sum_d[3] = p[4] ^ c[3];
    c4_d     = c[4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      c4_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      c4_q  <= c4_d;
    end
  end

  assign bus.s1 = sum_q[0];
  assign bus.s2 = sum_q[1];
  assign bus.s3 = sum_q[2];
  assign bus.s4 = sum_q[3];
  assign bus.c4 = c4_q;

endmodule

// File: tb/tb_cla4_registered.sv
// Directed and exhaustive checks of the registered 4-bit lookahead adder,
// comparing {c4,s4..s1} against hand-computed or arithmetic sums.
module tb_cla4_registered;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  cla4_registered_if bus ();

  cla4_registered u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] result_get();
    return {bus.c4, bus.s4, bus.s3, bus.s2, bus.s1};
  endfunction

  task automatic check_res(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive_ops(input logic [3:0] a, input logic [3:0] b, input logic cin);
    bus.a1 = a[0]; bus.a2 = a[1]; bus.a3 = a[2]; bus.a4 = a[3];
    bus.b1 = b[0]; bus.b2 = b[1]; bus.b3 = b[2]; bus.b4 = b[3];
    bus.c0 = cin;
  endtask

  // Drive at the falling edge, check 1 time unit after the next rising edge.
  task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic [4:0] exp);
    @(negedge clk);
    drive_ops(a, b, cin);
    @(posedge clk);
    #1;
    check_res(tag, result_get(), exp);
  endtask

  initial begin
    logic [4:0] exp_sum;
    n_tests = 0;
    n_fail  = 0;

    rst_n = 1'b0;
    drive_ops(4'd15, 4'd15, 1'b1);
    #1;
    check_res("reset_t0", result_get(), 5'b00000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_res("reset_hold", result_get(), 5'b00000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_res("reset_release_31", result_get(), 5'b11111);

    apply("zero",        4'b0000, 4'b0000, 1'b0, 5'b00000);
    apply("zero_cin",    4'b0000, 4'b0000, 1'b1, 5'b00001);
    apply("prop_chain",  4'b0101, 4'b1010, 1'b1, 5'b10000);
    apply("gen_msb",     4'b1000, 4'b1000, 1'b0, 5'b10000);
    apply("carry_ripple",4'b0111, 4'b0001, 1'b0, 5'b01000);

    apply("lat_3p4", 4'd3, 4'd4, 1'b0, 5'b00111);
    #2;
    drive_ops(4'd9, 4'd9, 1'b0);
    #1;
    check_res("lat_hold_7", result_get(), 5'b00111);
    @(posedge clk);
    #1;
    check_res("lat_9p9", result_get(), 5'b10010);

    for (int v = 0; v < 512; v++) begin
      logic [8:0] vec;
      vec     = v[8:0];
      exp_sum = {1'b0, vec[3:0]} + {1'b0, vec[7:4]} + {4'b0000, vec[8]};
      apply("sweep", vec[3:0], vec[7:4], vec[8], exp_sum);
      if (v == 200) begin
        rst_n = 1'b0;
        #1;
        check_res("sweep_async_reset", result_get(), 5'b00000);
        #1;
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
